quick_spi_arbiter: RTL and testbench

Round-robin arbiter and sequencer that shares one `quick_spi` master among up to `NUM_REQ` requesters. It sits between client blocks (config loaders, sensor pollers) and `quick_spi`. It latches the winning requester's slave/operation/payload, launches the transaction and waits for `end_of_transaction`. It then returns read data plus a one-cycle done (or timeout error) to that requester only.

---
 rtl/quick_spi_pkg.sv | 21 ++
 rtl/rr_pick.sv | 30 +++
 rtl/quick_spi_arbiter.sv | 137 +++++++++++++
 tb/tb_quick_spi_arbiter.sv | 354 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/quick_spi_pkg.sv
// Shared definitions for the quick_spi arbiter: default widths, operation
// codes and the 2-bit sequencer state encoding.
package quick_spi_pkg;

  localparam int DEF_NUM_REQ        = 4;
  localparam int DEF_OUT_WIDTH      = 16;
  localparam int DEF_IN_WIDTH       = 8;
  localparam int DEF_SLAVE_WIDTH    = 2;
  localparam int DEF_TIMEOUT_CYCLES = 4096;

  localparam logic OP_WRITE = 1'b1;
  localparam logic OP_READ  = 1'b0;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_LAUNCH   = 2'd1,
    ST_WAIT     = 2'd2,
    ST_COMPLETE = 2'd3
  } arb_state_t;

endpackage

// File: rtl/rr_pick.sv
// Combinational cyclic priority encoder: returns the first set request bit
// at or after ptr, wrapping around to index 0.
module rr_pick #(
  parameter int N     = 4,
  parameter int IDX_W = $clog2(N)
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] ptr,
  output logic             valid,
  output logic [IDX_W-1:0] idx
);

  logic [IDX_W:0] pos;

  // Scan offsets from farthest to nearest so the nearest hit to ptr wins last.
  always_comb begin
    valid = 1'b0;
    idx   = '0;
    pos   = '0;
    for (int k = N - 1; k >= 0; k--) begin
      pos = {1'b0, ptr} + (IDX_W + 1)'(k);
      if (pos >= (IDX_W + 1)'(N)) pos = pos - (IDX_W + 1)'(N);
      if (req[pos[IDX_W-1:0]]) begin
        valid = 1'b1;
        idx   = pos[IDX_W-1:0];
      end
    end
  end

endmodule

// File: rtl/quick_spi_arbiter.sv
// Round-robin arbiter/sequencer sharing one quick_spi master among NUM_REQ
// requesters.
// Handshake: a requester holds req[i] high with its op/slave/wdata valid;
// the request is accepted on the IDLE edge that latches it (gnt rises the
// next cycle), and the requester is released by a one-cycle done[i] (with err
// on timeout). Toward quick_spi, spi_start is a one-cycle launch pulse and
// spi_end is honoured only while waiting; spi_rdata is sampled with spi_end.
module quick_spi_arbiter
  import quick_spi_pkg::*;
#(
  parameter int NUM_REQ        = DEF_NUM_REQ,
  parameter int OUT_WIDTH      = DEF_OUT_WIDTH,
  parameter int IN_WIDTH       = DEF_IN_WIDTH,
  parameter int SLAVE_WIDTH    = DEF_SLAVE_WIDTH,
  parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic [NUM_REQ-1:0]             req,
  input  logic [NUM_REQ-1:0]             req_op,
  input  logic [NUM_REQ*SLAVE_WIDTH-1:0] req_slave,
  input  logic [NUM_REQ*OUT_WIDTH-1:0]   req_wdata,
  output logic [NUM_REQ-1:0]             gnt,
  output logic [NUM_REQ-1:0]             done,
  output logic                           err,
  output logic [IN_WIDTH-1:0]            rdata,
  output logic                           spi_start,
  output logic                           spi_op,
  output logic [SLAVE_WIDTH-1:0]         spi_slave,
  output logic [OUT_WIDTH-1:0]           spi_wdata,
  input  logic                           spi_end,
  input  logic [IN_WIDTH-1:0]            spi_rdata,
  output arb_state_t                     dbg_state
);

  localparam int IDX_W = $clog2(NUM_REQ);
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES);

  arb_state_t         state, state_nxt;
  logic [IDX_W-1:0]   ptr, winner, pick_idx;
  logic               pick_valid, mask_on, err_flag;
  logic [CNT_W-1:0]   cnt;
  logic [NUM_REQ-1:0] win_oh, req_eff;
  logic               cnt_last;

  assign win_oh    = NUM_REQ'(1) << winner;
  // The just-served requester is ignored for one IDLE cycle so it can drop req.
  assign req_eff   = req & ~(mask_on ? win_oh : '0);
  assign cnt_last  = (cnt == CNT_W'(TIMEOUT_CYCLES - 1));
  assign dbg_state = state;

  rr_pick #(.N(NUM_REQ), .IDX_W(IDX_W)) u_pick (
    .req   (req_eff),
    .ptr   (ptr),
    .valid (pick_valid),
    .idx   (pick_idx)
  );

  // Sequencer state register.
  always_ff @(posedge clk) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  // Next-state decode and state-derived outputs.
  always_comb begin
    state_nxt = state;
    gnt       = '0;
    done      = '0;
    err       = 1'b0;
    spi_start = 1'b0;
    case (state)
      ST_IDLE:   if (pick_valid) state_nxt = ST_LAUNCH;
      ST_LAUNCH: begin
        gnt       = win_oh;
        spi_start = 1'b1;
        state_nxt = ST_WAIT;
      end
      ST_WAIT: begin
        gnt = win_oh;
        if (spi_end || cnt_last) state_nxt = ST_COMPLETE;
      end
      ST_COMPLETE: begin
        gnt       = win_oh;
        done      = win_oh;
        err       = err_flag;
        state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Latch the winner's transaction, run the timeout counter, capture read data.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ptr       <= '0;
      winner    <= '0;
      mask_on   <= 1'b0;
      err_flag  <= 1'b0;
      cnt       <= '0;
      rdata     <= '0;
      spi_op    <= 1'b0;
      spi_slave <= '0;
      spi_wdata <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          mask_on <= 1'b0;
          if (pick_valid) begin
            winner    <= pick_idx;
            err_flag  <= 1'b0;
            spi_op    <= req_op[pick_idx];
            spi_slave <= req_slave[pick_idx*SLAVE_WIDTH +: SLAVE_WIDTH];
            spi_wdata <= req_wdata[pick_idx*OUT_WIDTH +: OUT_WIDTH];
          end
        end
        ST_LAUNCH: cnt <= '0;
        ST_WAIT: begin
          if (spi_end) begin
            if (spi_op == OP_READ) rdata <= spi_rdata;
          end else if (cnt_last) begin
            err_flag <= 1'b1;
            rdata    <= '0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        ST_COMPLETE: begin
          ptr     <= (winner == IDX_W'(NUM_REQ - 1)) ? '0 : winner + 1'b1;
          mask_on <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_quick_spi_arbiter.sv
// Self-checking bench for quick_spi_arbiter: directed scenarios plus a random
// phase, checked every cycle against a transaction-level arbitration model
// and a simple quick_spi slave model.
module tb_quick_spi_arbiter;
  import quick_spi_pkg::*;

  localparam int N  = 4;
  localparam int OW = 16;
  localparam int IW = 8;
  localparam int SW = 2;
  localparam int TO = 16;

  logic            clk;
  logic            rst_n;
  logic [N-1:0]    req, req_op;
  logic [N*SW-1:0] req_slave;
  logic [N*OW-1:0] req_wdata;
  logic [N-1:0]    gnt, done;
  logic            err;
  logic [IW-1:0]   rdata;
  logic            spi_start, spi_op;
  logic [SW-1:0]   spi_slave;
  logic [OW-1:0]   spi_wdata;
  logic            spi_end;
  logic [IW-1:0]   spi_rdata;
  arb_state_t      dbg_state;

  quick_spi_arbiter #(
    .NUM_REQ(N), .OUT_WIDTH(OW), .IN_WIDTH(IW), .SLAVE_WIDTH(SW), .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .req_op(req_op), .req_slave(req_slave),
    .req_wdata(req_wdata), .gnt(gnt), .done(done), .err(err), .rdata(rdata),
    .spi_start(spi_start), .spi_op(spi_op), .spi_slave(spi_slave), .spi_wdata(spi_wdata),
    .spi_end(spi_end), .spi_rdata(spi_rdata), .dbg_state(dbg_state)
  );

  // Clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Watchdog so the run always ends.
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  int  n_vec = 0;
  int  n_err = 0;
  int  cyc   = 0;
  bit  chk_en = 0;

  // Driver-side request state, applied one cycle after it is set.
  logic [N-1:0]  drv_req, drv_op;
  logic [SW-1:0] drv_slave [N];
  logic [OW-1:0] drv_wdata [N];
  logic          drv_rst_n;
  bit            timeout_mode;
  int            force_d;
  bit            force_rd_en;
  logic [IW-1:0] force_rd_val;
  logic          nxt_end;
  logic [IW-1:0] nxt_rdata;

  // Reference model state.
  bit            m_busy, exp_launch, m_mask_on, m_to;
  int            m_ptr, m_win, m_mask_idx, m_k, m_end_k;
  logic          m_op;
  logic [SW-1:0] m_slave;
  logic [OW-1:0] m_wdata;
  logic [IW-1:0] m_rdata, m_resp;
  logic [7:0]    exp_q [$];
  int            obs_q [$];
  int            start_cyc, done_cyc, n_starts;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Per-cycle check against the model, then advance the model one cycle.
  task automatic model_step();
    logic [N-1:0] oh, eligible, sb_oh;
    logic [7:0]   sb_idx;
    bit           compl, found;
    int           pos;
    cyc++;
    oh    = N'(1) << m_win;
    compl = m_busy && (m_k == m_end_k + 1);
    if (spi_start === 1'b1) begin
      n_starts++;
      start_cyc = cyc;
      for (int i = 0; i < N; i++) if (gnt[i] === 1'b1) obs_q.push_back(i);
    end
    if (done !== '0) done_cyc = cyc;
    if (compl) begin
      if (m_to) m_rdata = '0;
      else if (m_op == OP_READ) m_rdata = m_resp;
    end
    if (chk_en) begin
      check_eq("spi_start", spi_start, exp_launch);
      check_eq("gnt", gnt, m_busy ? oh : '0);
      check_eq("spi_op", spi_op, m_op);
      check_eq("spi_slave", spi_slave, m_slave);
      check_eq("spi_wdata", spi_wdata, m_wdata);
      check_eq("done", done, compl ? oh : '0);
      check_eq("err", err, compl && m_to);
      check_eq("rdata", rdata, m_rdata);
      if (done !== '0) begin
        if (exp_q.size() == 0) check_eq("done_unexpected", done, '0);
        else begin
          sb_idx = exp_q.pop_front();
          sb_oh  = N'(1) << sb_idx;
          check_eq("done_scoreboard", done, sb_oh);
        end
      end
    end
    if (!rst_n) begin
      m_busy = 0; exp_launch = 0; m_ptr = 0; m_mask_on = 0; m_win = 0;
      m_op = 0; m_slave = '0; m_wdata = '0; m_rdata = '0; m_k = 0; m_end_k = 0;
      exp_q.delete();
    end else if (compl) begin
      m_busy = 0; exp_launch = 0;
      m_ptr = (m_win + 1) % N;
      m_mask_on = 1; m_mask_idx = m_win;
    end else if (!m_busy) begin
      eligible = req;
      if (m_mask_on) eligible[m_mask_idx] = 1'b0;
      m_mask_on = 0; exp_launch = 0; found = 0;
      for (int k = 0; k < N; k++) begin
        pos = (m_ptr + k) % N;
        if (!found && eligible[pos]) begin found = 1; m_win = pos; end
      end
      if (found) begin
        exp_launch = 1; m_busy = 1; m_k = 0;
        m_op    = req_op[m_win];
        m_slave = req_slave[m_win*SW +: SW];
        m_wdata = req_wdata[m_win*OW +: OW];
        m_to    = timeout_mode;
        m_end_k = m_to ? TO : ((force_d > 0) ? force_d : $urandom_range(1, 8));
        m_resp  = force_rd_en ? force_rd_val : IW'($urandom);
        exp_q.push_back(8'(m_win));
      end
    end else begin
      m_k++;
      exp_launch = 0;
    end
    // Slave model: answer at the chosen cycle; stray spi_end only when not waiting.
    nxt_end   = 1'b0;
    nxt_rdata = IW'($urandom);
    if (m_busy && !m_to && m_k == m_end_k) begin
      nxt_end   = 1'b1;
      nxt_rdata = m_resp;
    end else if (!m_busy || exp_launch) begin
      nxt_end = ($urandom_range(0, 7) == 0);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    rst_n  = drv_rst_n;
    req    = drv_req;
    req_op = drv_op;
    for (int i = 0; i < N; i++) begin
      req_slave[i*SW +: SW] = drv_slave[i];
      req_wdata[i*OW +: OW] = drv_wdata[i];
    end
    spi_end   = nxt_end;
    spi_rdata = nxt_rdata;
    @(negedge clk);
    model_step();
  endtask

  task automatic wait_start(input int budget);
    bit seen = 0;
    for (int i = 0; i < budget && !seen; i++) begin
      tick();
      if (spi_start === 1'b1) seen = 1;
    end
    check_eq("start_within_budget", seen, 1'b1);
  endtask

  task automatic wait_done(input int budget);
    bit seen = 0;
    for (int i = 0; i < budget && !seen; i++) begin
      tick();
      if (done !== '0) seen = 1;
    end
    check_eq("done_within_budget", seen, 1'b1);
  endtask

  task automatic pulse_reset();
    drv_rst_n = 0; tick();
    drv_rst_n = 1; tick();
  endtask

  int            exp_order [5] = '{0, 1, 2, 3, 0};
  int            ndone, cnt_done;
  bit            re0;
  logic [IW-1:0] prev_rdata;

  initial begin
    drv_req = '0; drv_op = '0; drv_rst_n = 0;
    for (int i = 0; i < N; i++) begin drv_slave[i] = '0; drv_wdata[i] = '0; end
    timeout_mode = 0; force_d = 0; force_rd_en = 0; force_rd_val = '0;
    nxt_end = 0; nxt_rdata = '0; n_starts = 0;
    m_busy = 0; exp_launch = 0; m_mask_on = 0; m_ptr = 0; m_win = 0; m_mask_idx = 0;
    m_k = 0; m_end_k = 0; m_to = 0; m_op = 0; m_slave = '0; m_wdata = '0;
    m_rdata = '0; m_resp = '0;
    rst_n = 0; req = '0; req_op = '0; req_slave = '0; req_wdata = '0;
    spi_end = 0; spi_rdata = '0;

    // Reset: outputs are unknown in the very first cycle, checked from then on.
    tick();
    chk_en = 1;
    tick();
    check_eq("rst_state", dbg_state, ST_IDLE);
    check_eq("rst_gnt", gnt, '0);
    check_eq("rst_done", done, '0);
    check_eq("rst_rdata", rdata, '0);
    drv_rst_n = 1;
    tick();

    // Single read by requester 2.
    drv_req = 4'b0100; drv_op[2] = OP_READ; drv_slave[2] = 2'd1; drv_wdata[2] = 16'h1A6A;
    force_rd_en = 1; force_rd_val = 8'h95; force_d = 3; n_starts = 0;
    wait_start(20);
    check_eq("rd_slave", spi_slave, 2'd1);
    check_eq("rd_op", spi_op, OP_READ);
    check_eq("rd_gnt", gnt, 4'b0100);
    wait_done(40);
    check_eq("rd_done", done, 4'b0100);
    check_eq("rd_rdata", rdata, 8'h95);
    check_eq("rd_err", err, 1'b0);
    check_eq("rd_one_start", n_starts, 1);
    drv_req = '0; force_rd_en = 0; force_d = 0;
    tick(); tick();

    // All four request with ptr=0; requester 0 re-requests after its done.
    pulse_reset();
    obs_q.delete(); ndone = 0; re0 = 0;
    drv_req = 4'b1111;
    for (int i = 0; i < N; i++) drv_op[i] = OP_READ;
    for (int c = 0; c < 400 && ndone < 5; c++) begin
      tick();
      if (done !== '0) begin
        ndone++;
        for (int i = 0; i < N; i++) if (done[i]) begin
          if (i == 0 && !re0) re0 = 1;
          else drv_req[i] = 1'b0;
        end
      end
    end
    check_eq("rr_count", obs_q.size(), 5);
    for (int k = 0; k < 5; k++)
      check_eq("rr_order", (k < obs_q.size()) ? obs_q[k] : -1, exp_order[k]);
    drv_req = '0;
    tick(); tick();

    // Write by requester 1: payload held through the wait, rdata untouched.
    prev_rdata = rdata;
    drv_req = 4'b0010; drv_op[1] = OP_WRITE; drv_slave[1] = 2'd3; drv_wdata[1] = 16'h00FF;
    force_d = 5;
    wait_start(20);
    drv_wdata[1] = 16'hBEEF; drv_slave[1] = 2'd0;
    ndone = 0;
    for (int c = 0; c < 50 && ndone == 0; c++) begin
      tick();
      if (done !== '0) ndone = 1;
      else check_eq("wr_wdata_stable", spi_wdata, 16'h00FF);
    end
    check_eq("wr_done", done, 4'b0010);
    check_eq("wr_rdata_kept", rdata, prev_rdata);
    drv_req = '0; drv_op[1] = OP_READ; force_d = 0;
    tick(); tick();

    // Timeout on requester 3, then requester 0 served normally.
    timeout_mode = 1; drv_req = 4'b1000; drv_op[3] = OP_READ;
    wait_start(20);
    timeout_mode = 0; drv_req[0] = 1'b1;
    wait_done(40);
    check_eq("to_done", done, 4'b1000);
    check_eq("to_err", err, 1'b1);
    check_eq("to_rdata", rdata, '0);
    check_eq("to_latency", done_cyc - start_cyc, 17);
    drv_req[3] = 1'b0;
    wait_start(20);
    check_eq("after_to_gnt", gnt, 4'b0001);
    wait_done(40);
    check_eq("after_to_err", err, 1'b0);
    drv_req = '0;
    tick(); tick();

    // Sole requester holds req through done: masked for one idle cycle.
    drv_req = 4'b0010;
    wait_done(40);
    tick();
    check_eq("mask_c1_start", spi_start, 1'b0);
    tick();
    check_eq("mask_c2_start", spi_start, 1'b0);
    tick();
    check_eq("regrant_start", spi_start, 1'b1);
    wait_done(40);
    drv_req = '0;
    tick(); tick();

    // Reset while waiting: reset values next cycle, no done afterwards.
    drv_req = 4'b0100; drv_op[2] = OP_WRITE; drv_wdata[2] = 16'h5A5A; force_d = 12;
    wait_start(20);
    drv_req = '0;
    tick(); tick(); tick();
    drv_rst_n = 0;
    tick();
    drv_rst_n = 1;
    tick();
    check_eq("rstw_state", dbg_state, ST_IDLE);
    check_eq("rstw_gnt", gnt, '0);
    check_eq("rstw_wdata", spi_wdata, '0);
    check_eq("rstw_op", spi_op, 1'b0);
    check_eq("rstw_rdata", rdata, '0);
    cnt_done = 0;
    for (int c = 0; c < 20; c++) begin
      tick();
      if (done !== '0) cnt_done++;
    end
    check_eq("rstw_no_done", cnt_done, 0);
    force_d = 0; drv_op[2] = OP_READ;

    // Random phase: free-running requests, payloads, timeouts and rare resets.
    for (int c = 0; c < 3000; c++) begin
      drv_req = N'($urandom_range(0, 15));
      drv_op  = N'($urandom_range(0, 15));
      for (int i = 0; i < N; i++) begin
        drv_slave[i] = SW'($urandom);
        drv_wdata[i] = OW'($urandom);
      end
      timeout_mode = ($urandom_range(0, 31) == 0);
      drv_rst_n    = !($urandom_range(0, 599) == 0);
      tick();
    end
    drv_rst_n = 1; drv_req = '0; timeout_mode = 0;
    for (int c = 0; c < 30; c++) tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
